urna_booth_arbiter: RTL

- Shares one vote-tally datapath (the urn counters for C1..C4 and Nulo) among NUM_BOOTHS voting terminals.
- Each booth presents one finished, decoded vote through a req/ack handshake.
- The arbiter serialises accepted votes round-robin into single-cycle tally-update strobes.
- It also sequences the election session (closed / open / draining), counts accepted votes, and reports status.

---
 rtl/urna_pkg.sv | 22 ++
 rtl/urna_rr_pick.sv | 28 ++
 rtl/urna_booth_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/urna_pkg.sv
// Shared vote-class codes and election session states for the urn datapath.
// The decoder, tally block and booth arbiter all agree on these encodings.
package urna_pkg;

    localparam logic [2:0] CLS_C1   = 3'd0;
    localparam logic [2:0] CLS_C2   = 3'd1;
    localparam logic [2:0] CLS_C3   = 3'd2;
    localparam logic [2:0] CLS_C4   = 3'd3;
    localparam logic [2:0] CLS_NULO = 3'd4;

    typedef enum logic [1:0] {
        S_CLOSED = 2'd0,
        S_OPEN   = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    // Any code outside the candidate/Nulo range is counted as a Nulo vote.
    function automatic logic [2:0] clamp_class(input logic [2:0] code);
        return (code > CLS_NULO) ? CLS_NULO : code;
    endfunction

endpackage

// File: rtl/urna_rr_pick.sv
// Combinational round-robin picker: first set bit of the eligible mask,
// scanning upward from ptr and wrapping around at N.
module urna_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_found
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        idx         = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDX_W'((int'(ptr) + k) % N);
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/urna_booth_arbiter.sv
// Serialises finished votes from NUM_BOOTHS booths into single-cycle tally
// updates and sequences the election session (closed / open / draining).
module urna_booth_arbiter
    import urna_pkg::*;
#(
    parameter int NUM_BOOTHS = 4,
    parameter int TOTAL_W    = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    open,
    input  logic                    close,
    input  logic [NUM_BOOTHS-1:0]   req,
    input  logic [3*NUM_BOOTHS-1:0] code,
    output logic [NUM_BOOTHS-1:0]   ack,
    output logic                    upd_valid,
    output logic [2:0]              upd_class,
    output logic [2:0]              upd_booth,
    output logic                    status,
    output logic                    busy,
    output logic [TOTAL_W-1:0]      total,
    output state_t                  dbg_state,
    output logic [2:0]              dbg_ptr
);

    // Handshake: a booth raises req with a stable code and holds both until
    // ack pulses for one cycle (granted the cycle before); it drops req the
    // cycle after ack and waits at least two cycles before requesting again.

    localparam int IDX_W = $clog2(NUM_BOOTHS);
    localparam logic [TOTAL_W-1:0] TOTAL_MAX = '1;

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        ptr;
    logic [NUM_BOOTHS-1:0]   snap, snap_nxt;
    logic [NUM_BOOTHS-1:0]   allow, eligible, grant_oh;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_found;
    logic [2:0]              sel_code;

    // The booth acked this cycle was served last cycle; masking it stops a
    // double grant while its req is still high.
    always_comb begin
        allow = '0;
        case (state)
            S_OPEN:  allow = '1;
            S_DRAIN: allow = snap;
            default: allow = '0;
        endcase
        eligible = req & ~ack & allow;
    end

    urna_rr_pick #(
        .N     (NUM_BOOTHS),
        .IDX_W (IDX_W)
    ) u_pick (
        .eligible    (eligible),
        .ptr         (ptr),
        .grant_idx   (grant_idx),
        .grant_found (grant_found)
    );

    always_comb begin
        grant_oh = '0;
        sel_code = '0;
        for (int i = 0; i < NUM_BOOTHS; i++) begin
            if (grant_found && grant_idx == IDX_W'(i)) begin
                grant_oh[i] = 1'b1;
                sel_code    = code[3*i +: 3];
            end
        end
    end

    // A booth granted at the closing edge is already being served, so it is
    // kept out of the snapshot; otherwise the drain would wait on it forever.
    always_comb begin
        state_nxt = state;
        snap_nxt  = snap;
        case (state)
            S_CLOSED: begin
                if (open) state_nxt = S_OPEN;
            end
            S_OPEN: begin
                if (close) begin
                    state_nxt = S_DRAIN;
                    snap_nxt  = req & ~ack & ~grant_oh;
                end
            end
            S_DRAIN: begin
                snap_nxt = snap & ~grant_oh;
                if (snap == '0) state_nxt = S_CLOSED;
            end
            default: state_nxt = S_CLOSED;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_CLOSED;
            snap      <= '0;
            ptr       <= '0;
            ack       <= '0;
            upd_valid <= 1'b0;
            upd_class <= '0;
            upd_booth <= '0;
            total     <= '0;
        end else begin
            state     <= state_nxt;
            snap      <= snap_nxt;
            ack       <= grant_oh;
            upd_valid <= grant_found;
            if (grant_found) begin
                upd_class <= clamp_class(sel_code);
                upd_booth <= 3'(grant_idx);
                ptr       <= (grant_idx == IDX_W'(NUM_BOOTHS - 1)) ? '0 : grant_idx + 1'b1;
            end else begin
                upd_class <= '0;
                upd_booth <= '0;
            end
            if (state == S_CLOSED && open) begin
                total <= '0;
            end else if (upd_valid && total != TOTAL_MAX) begin
                total <= total + 1'b1;
            end
        end
    end

    assign status    = (state == S_OPEN);
    assign busy      = (state == S_DRAIN);
    assign dbg_state = state;
    assign dbg_ptr   = 3'(ptr);

endmodule
